dcd_fwd_unit: RTL and testbench

//  Decode-stage operand forwarding/hazard unit. Tracks in-flight destination tags of the DEPTH

---
 rtl/dcd_fwd_unit.sv | 138 +++++++++++++
 tb/tb_dcd_fwd_unit.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcd_fwd_unit.sv
// Decode-stage operand forwarding and load-use hazard unit with a DEPTH-slot destination shadow pipeline.
// Optional build macro DCD_FWD_STATS_EN adds saturating stall_cnt / fwd_cnt outputs.
module dcd_fwd_unit #(
   parameter int unsigned WORD_WIDTH     = 32,
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned NUM_SRC        = 2,
   parameter int unsigned DEPTH          = 3
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               inst_valid,
   input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0]  rs_tag,
   input  logic [NUM_SRC-1:0]                 rs_used,
   input  logic [NUM_SRC*WORD_WIDTH-1:0]      reg_data_out,
   input  logic [REG_ADDR_WIDTH-1:0]          rd_tag,
   input  logic                               rd_wren,
   input  logic                               pipe_adv,
   input  logic                               flush,
   input  logic [DEPTH*WORD_WIDTH-1:0]        stg_data,
   input  logic [DEPTH-1:0]                   stg_data_vld,
   output logic [NUM_SRC*WORD_WIDTH-1:0]      rs_pipe_data,
   output logic [NUM_SRC-1:0]                 fwd_hit,
   output logic                               stall
`ifdef DCD_FWD_STATS_EN
   ,
   output logic [31:0]                        stall_cnt,
   output logic [31:0]                        fwd_cnt
`endif
);

   logic [REG_ADDR_WIDTH-1:0] slot_tag [DEPTH];
   logic [DEPTH-1:0]          slot_wren;
   logic [REG_ADDR_WIDTH-1:0] tag_nxt  [DEPTH];
   logic [DEPTH-1:0]          wren_nxt;
   logic [NUM_SRC-1:0]        pending;
   logic                      insert;

   assign insert = inst_valid & ~stall;

   always_comb begin
      wren_nxt = slot_wren;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         tag_nxt[i] = slot_tag[i];
      end
      if (pipe_adv) begin
         for (int unsigned i = 1; i < DEPTH; i++) begin
            tag_nxt[i]  = slot_tag[i-1];
            wren_nxt[i] = slot_wren[i-1];
         end
         tag_nxt[0]  = insert ? rd_tag : '0;
         wren_nxt[0] = insert & rd_wren;
      end
      // Flush squashes every wrong-path slot; the writeback slot keeps its own entry
      // rather than taking the squashed one shifting into it.
      if (flush) begin
         for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
            wren_nxt[i] = 1'b0;
         end
         if (DEPTH > 1) begin
            tag_nxt[DEPTH-1]  = slot_tag[DEPTH-1];
            wren_nxt[DEPTH-1] = slot_wren[DEPTH-1];
         end else begin
            wren_nxt[0] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_wren <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            slot_tag[i] <= '0;
         end
      end else if (pipe_adv || flush) begin
         slot_wren <= wren_nxt;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            slot_tag[i] <= tag_nxt[i];
         end
      end
   end

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      logic [REG_ADDR_WIDTH-1:0] src_tag;
      logic [WORD_WIDTH-1:0]     src_data;
      logic                      src_hit;
      logic                      src_pend;
      logic                      found;

      assign src_tag = rs_tag[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];

      // Scan from the youngest slot; the first match decides, older matches are ignored.
      always_comb begin
         src_data = reg_data_out[k*WORD_WIDTH +: WORD_WIDTH];
         src_hit  = 1'b0;
         src_pend = 1'b0;
         found    = 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!found && slot_wren[i] && (slot_tag[i] == src_tag) && (src_tag != '0)) begin
               found = 1'b1;
               if (stg_data_vld[i]) begin
                  src_data = stg_data[i*WORD_WIDTH +: WORD_WIDTH];
                  src_hit  = 1'b1;
               end else begin
                  src_pend = 1'b1;
               end
            end
         end
      end

      assign rs_pipe_data[k*WORD_WIDTH +: WORD_WIDTH] = src_data;
      assign fwd_hit[k] = src_hit;
      assign pending[k] = src_pend;
   end

   assign stall = inst_valid & (|(pending & rs_used));

`ifdef DCD_FWD_STATS_EN
   logic fwd_issue;

   assign fwd_issue = insert & (|(fwd_hit & rs_used));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         fwd_cnt   <= '0;
      end else begin
         if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (fwd_issue && (fwd_cnt != '1)) begin
            fwd_cnt <= fwd_cnt + 32'd1;
         end
      end
   end
`else
`endif

endmodule

// File: tb/tb_dcd_fwd_unit.sv
// Self-checking bench for dcd_fwd_unit: scenario tasks push expected outputs to a queue
// when driving stimulus and pop/compare them when the combinational outputs are sampled.
module tb_dcd_fwd_unit;
   localparam int W   = 32;
   localparam int RAW = 5;
   localparam int NS  = 2;
   localparam int D   = 3;

   localparam logic [W-1:0] REG0 = 32'hAAAA_0000;
   localparam logic [W-1:0] REG1 = 32'hBBBB_0001;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              inst_valid;
   logic [NS*RAW-1:0] rs_tag;
   logic [NS-1:0]     rs_used;
   logic [NS*W-1:0]   reg_data_out;
   logic [RAW-1:0]    rd_tag;
   logic              rd_wren;
   logic              pipe_adv;
   logic              flush;
   logic [D*W-1:0]    stg_data;
   logic [D-1:0]      stg_data_vld;
   logic [NS*W-1:0]   rs_pipe_data;
   logic [NS-1:0]     fwd_hit;
   logic              stall;
`ifdef DCD_FWD_STATS_EN
   logic [31:0]       stall_cnt;
   logic [31:0]       fwd_cnt;
`endif

   typedef struct {
      string          name;
      logic [NS*W-1:0] data;
      logic [NS-1:0]  hit;
      logic           stall;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   dcd_fwd_unit #(
      .WORD_WIDTH(W),
      .REG_ADDR_WIDTH(RAW),
      .NUM_SRC(NS),
      .DEPTH(D)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .inst_valid(inst_valid),
      .rs_tag(rs_tag),
      .rs_used(rs_used),
      .reg_data_out(reg_data_out),
      .rd_tag(rd_tag),
      .rd_wren(rd_wren),
      .pipe_adv(pipe_adv),
      .flush(flush),
      .stg_data(stg_data),
      .stg_data_vld(stg_data_vld),
      .rs_pipe_data(rs_pipe_data),
      .fwd_hit(fwd_hit),
      .stall(stall)
`ifdef DCD_FWD_STATS_EN
      ,
      .stall_cnt(stall_cnt),
      .fwd_cnt(fwd_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      inst_valid   = 1'b0;
      rs_tag       = '0;
      rs_used      = '0;
      rd_tag       = '0;
      rd_wren      = 1'b0;
      pipe_adv     = 1'b0;
      flush        = 1'b0;
      stg_data     = '0;
      stg_data_vld = '0;
   endtask

   task automatic do_reset;
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic issue(input logic [RAW-1:0] rd);
      inst_valid = 1'b1;
      rd_tag     = rd;
      rd_wren    = 1'b1;
      rs_used    = '0;
      pipe_adv   = 1'b1;
      tick();
      inst_valid = 1'b0;
      rd_wren    = 1'b0;
      pipe_adv   = 1'b0;
   endtask

   task automatic set_stg(input int i, input logic [W-1:0] v);
      stg_data[i*W +: W] = v;
   endtask

   task automatic test_reset;
      exp_t e;
      logic [NS*W-1:0] x;
      rst_n = 1'b0;
      idle_inputs();
      inst_valid = 1'b1;
      rs_tag     = {5'd1, 5'd1};
      rs_used    = 2'b11;
      exp_q.push_back('{"reset_init", {REG1, REG0}, 2'b00, 1'b0});
      #2;
      e = exp_q.pop_front();
      checks++; if (rs_pipe_data !== e.data) begin failures++; $display("FAIL %s data got=%h want=%h", e.name, rs_pipe_data, e.data); end
      checks++; if (fwd_hit !== e.hit) begin failures++; $display("FAIL %s hit got=%b want=%b", e.name, fwd_hit, e.hit); end
      checks++; if (stall !== e.stall) begin failures++; $display("FAIL %s stall got=%b want=%b", e.name, stall, e.stall); end

      @(negedge clk);
      rst_n = 1'b1;
      idle_inputs();
      tick();
      issue(5'd1);
      issue(5'd2);
      issue(5'd3);
      inst_valid   = 1'b1;
      rs_tag       = {5'd1, 5'd3};
      rs_used      = 2'b11;
      stg_data_vld = 3'b100;
      set_stg(2, 32'h0000_C0DE);
      x = {32'h0000_C0DE, REG0};
      exp_q.push_back('{"reset_full", x, 2'b10, 1'b1});
      #1;
      e = exp_q.pop_front();
      checks++; if (rs_pipe_data !== e.data) begin failures++; $display("FAIL %s data got=%h want=%h", e.name, rs_pipe_data, e.data); end
      checks++; if (fwd_hit !== e.hit) begin failures++; $display("FAIL %s hit got=%b want=%b", e.name, fwd_hit, e.hit); end
      checks++; if (stall !== e.stall) begin failures++; $display("FAIL %s stall got=%b want=%b", e.name, stall, e.stall); end

      rst_n = 1'b0;
      exp_q.push_back('{"reset_async", {REG1, REG0}, 2'b00, 1'b0});
      #1;
      e = exp_q.pop_front();
      checks++; if (rs_pipe_data !== e.data) begin failures++; $display("FAIL %s data got=%h want=%h", e.name, rs_pipe_data, e.data); end
      checks++; if (fwd_hit !== e.hit) begin failures++; $display("FAIL %s hit got=%b want=%b", e.name, fwd_hit, e.hit); end
      checks++; if (stall !== e.stall) begin failures++; $display("FAIL %s stall got=%b want=%b", e.name, stall, e.stall); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      exp_q.push_back('{"reset_after", {REG1, REG0}, 2'b00, 1'b0});
      e = exp_q.pop_front();
      checks++; if (rs_pipe_data !== e.data) begin failures++; $display("FAIL %s data got=%h want=%h", e.name, rs_pipe_data, e.data); end
      checks++; if (stall !== e.stall) begin failures++; $display("FAIL %s stall got=%b want=%b", e.name, stall, e.stall); end
   endtask

   task automatic test_ex_forward;
      exp_t e;
      do_reset();
      issue(5'd5);
      inst_valid   = 1'b1;
      rs_tag       = {5'd0, 5'd5};
      rs_used      = 2'b01;
      stg_data_vld = 3'b001;
      set_stg(0, 32'h0000_A5A5);
      exp_q.push_back('{"ex_fwd", {REG1, 32'h0000_A5A5}, 2'b01, 1'b0});
      #1;
      e = exp_q.pop_front();
      checks++; if (rs_pipe_data !== e.data) begin failures++; $display("FAIL %s data got=%h want=%h", e.name, rs_pipe_data, e.data); end
      checks++; if (fwd_hit !== e.hit) begin failures++; $display("FAIL %s hit got=%b want=%b", e.name, fwd_hit, e.hit); end
      checks++; if (stall !== e.stall) begin failures++; $display("FAIL %s stall got=%b want=%b", e.name, stall, e.stall); end
   endtask

   task automatic test_load_use;
      exp_t e;
      do_reset();
      issue(5'd7);
      inst_valid   = 1'b1;
      rs_tag       = {5'd7, 5'd0};
      rs_used      = 2'b10;
      rd_tag       = 5'd9;
      rd_wren      = 1'b1;
      pipe_adv     = 1'b1;
      stg_data_vld = 3'b000;
      exp_q.push_back('{"load_use_stall", {REG1, REG0}, 2'b00, 1'b1});
      #1;
      e = exp_q.pop_front();
      checks++; if (rs_pipe_data !== e.data) begin failures++; $display("FAIL %s data got=%h want=%h", e.name, rs_pipe_data, e.data); end
      checks++; if (fwd_hit !== e.hit) begin failures++; $display("FAIL %s hit got=%b want=%b", e.name, fwd_hit, e.hit); end
      checks++; if (stall !== e.stall) begin failures++; $display("FAIL %s stall got=%b want=%b", e.name, stall, e.stall); end

      tick();
      pipe_adv     = 1'b0;
      rs_tag       = {5'd7, 5'd9};
      rs_used      = 2'b11;
      stg_data_vld = 3'b111;
      set_stg(1, 32'h0000_1234);
      exp_q.push_back('{"load_use_resolved", {32'h0000_1234, REG0}, 2'b10, 1'b0});
      #1;
      e = exp_q.pop_front();
      checks++; if (rs_pipe_data !== e.data) begin failures++; $display("FAIL %s data got=%h want=%h", e.name, rs_pipe_data, e.data); end
      checks++; if (fwd_hit !== e.hit) begin failures++; $display("FAIL %s hit got=%b want=%b", e.name, fwd_hit, e.hit); end
      checks++; if (stall !== e.stall) begin failures++; $display("FAIL %s stall got=%b want=%b", e.name, stall, e.stall); end
   endtask

   task automatic test_priority;
      exp_t e;
      do_reset();
      issue(5'd3);
      issue(5'd0);
      issue(5'd3);
      inst_valid   = 1'b1;
      rs_tag       = {5'd0, 5'd3};
      rs_used      = 2'b11;
      stg_data_vld = 3'b111;
      set_stg(0, 32'h0000_0011);
      set_stg(1, 32'h0000_0BAD);
      set_stg(2, 32'h0000_0022);
      exp_q.push_back('{"prio_youngest", {REG1, 32'h0000_0011}, 2'b01, 1'b0});
      #1;
      e = exp_q.pop_front();
      checks++; if (rs_pipe_data !== e.data) begin failures++; $display("FAIL %s data got=%h want=%h", e.name, rs_pipe_data, e.data); end
      checks++; if (fwd_hit !== e.hit) begin failures++; $display("FAIL %s hit got=%b want=%b", e.name, fwd_hit, e.hit); end
      checks++; if (stall !== e.stall) begin failures++; $display("FAIL %s stall got=%b want=%b", e.name, stall, e.stall); end

      stg_data_vld = 3'b100;
      exp_q.push_back('{"prio_young_pending", {REG1, REG0}, 2'b00, 1'b1});
      #1;
      e = exp_q.pop_front();
      checks++; if (rs_pipe_data !== e.data) begin failures++; $display("FAIL %s data got=%h want=%h", e.name, rs_pipe_data, e.data); end
      checks++; if (fwd_hit !== e.hit) begin failures++; $display("FAIL %s hit got=%b want=%b", e.name, fwd_hit, e.hit); end
      checks++; if (stall !== e.stall) begin failures++; $display("FAIL %s stall got=%b want=%b", e.name, stall, e.stall); end

      rs_used = 2'b10;
      exp_q.push_back('{"prio_unused_port", {REG1, REG0}, 2'b00, 1'b0});
      #1;
      e = exp_q.pop_front();
      checks++; if (stall !== e.stall) begin failures++; $display("FAIL %s stall got=%b want=%b", e.name, stall, e.stall); end

      rs_used    = 2'b11;
      inst_valid = 1'b0;
      exp_q.push_back('{"prio_no_inst", {REG1, REG0}, 2'b00, 1'b0});
      #1;
      e = exp_q.pop_front();
      checks++; if (stall !== e.stall) begin failures++; $display("FAIL %s stall got=%b want=%b", e.name, stall, e.stall); end
   endtask

   task automatic test_flush;
      exp_t e;
      do_reset();
      issue(5'd8);
      issue(5'd6);
      issue(5'd4);
      inst_valid = 1'b1;
      rd_tag     = 5'd10;
      rd_wren    = 1'b1;
      pipe_adv   = 1'b1;
      flush      = 1'b1;
      tick();
      inst_valid   = 1'b0;
      rd_wren      = 1'b0;
      pipe_adv     = 1'b0;
      flush        = 1'b0;
      stg_data_vld = 3'b111;
      set_stg(0, 32'hD000_0000);
      set_stg(1, 32'hD000_0001);
      set_stg(2, 32'hD000_0002);
      rs_tag       = {5'd4, 5'd6};
      rs_used      = 2'b11;
      exp_q.push_back('{"flush_dropped", {REG1, REG0}, 2'b00, 1'b0});
      #1;
      e = exp_q.pop_front();
      checks++; if (rs_pipe_data !== e.data) begin failures++; $display("FAIL %s data got=%h want=%h", e.name, rs_pipe_data, e.data); end
      checks++; if (fwd_hit !== e.hit) begin failures++; $display("FAIL %s hit got=%b want=%b", e.name, fwd_hit, e.hit); end

      rs_tag = {5'd10, 5'd8};
      exp_q.push_back('{"flush_wb_kept", {REG1, 32'hD000_0002}, 2'b01, 1'b0});
      #1;
      e = exp_q.pop_front();
      checks++; if (rs_pipe_data !== e.data) begin failures++; $display("FAIL %s data got=%h want=%h", e.name, rs_pipe_data, e.data); end
      checks++; if (fwd_hit !== e.hit) begin failures++; $display("FAIL %s hit got=%b want=%b", e.name, fwd_hit, e.hit); end
   endtask

   task automatic test_back_to_back;
      exp_t e;
      logic [RAW-1:0] t0, t1;
      logic [W-1:0]   d0, d1;
      logic [NS-1:0]  h;
      do_reset();
      for (int k = 1; k <= 6; k++) begin
         t0 = RAW'(k - 1);
         t1 = (k > 3) ? RAW'(k - 3) : '0;
         inst_valid   = 1'b1;
         rd_tag       = RAW'(k);
         rd_wren      = 1'b1;
         pipe_adv     = 1'b1;
         rs_used      = 2'b11;
         rs_tag       = {t1, t0};
         stg_data_vld = 3'b111;
         for (int i = 0; i < D; i++) set_stg(i, W'(32'h100 * k + i));
         d0   = (k >= 2) ? W'(32'h100 * k) : REG0;
         d1   = (k >= 4) ? W'(32'h100 * k + 2) : REG1;
         h    = {(k >= 4) ? 1'b1 : 1'b0, (k >= 2) ? 1'b1 : 1'b0};
         exp_q.push_back('{$sformatf("b2b_%0d", k), {d1, d0}, h, 1'b0});
         #1;
         e = exp_q.pop_front();
         checks++; if (rs_pipe_data !== e.data) begin failures++; $display("FAIL %s data got=%h want=%h", e.name, rs_pipe_data, e.data); end
         checks++; if (fwd_hit !== e.hit) begin failures++; $display("FAIL %s hit got=%b want=%b", e.name, fwd_hit, e.hit); end
         checks++; if (stall !== e.stall) begin failures++; $display("FAIL %s stall got=%b want=%b", e.name, stall, e.stall); end
         tick();
      end
      idle_inputs();
   endtask

`ifdef DCD_FWD_STATS_EN
   task automatic test_stats;
      do_reset();
      issue(5'd7);
      inst_valid   = 1'b1;
      rs_tag       = {5'd0, 5'd7};
      rs_used      = 2'b01;
      stg_data_vld = 3'b000;
      repeat (3) tick();
      stg_data_vld = 3'b001;
      set_stg(0, 32'h0000_0055);
      repeat (2) tick();
      inst_valid = 1'b0;
      #1;
      checks++; if (stall_cnt !== 32'd3) begin failures++; $display("FAIL stats_stall_cnt got=%0d want=3", stall_cnt); end
      checks++; if (fwd_cnt !== 32'd2) begin failures++; $display("FAIL stats_fwd_cnt got=%0d want=2", fwd_cnt); end

      force dut.stall_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt;
      inst_valid   = 1'b1;
      stg_data_vld = 3'b000;
      repeat (3) tick();
      inst_valid = 1'b0;
      checks++; if (stall_cnt !== 32'hFFFF_FFFF) begin failures++; $display("FAIL stats_saturate got=%h want=ffffffff", stall_cnt); end
   endtask
`endif

   initial begin
      reg_data_out = {REG1, REG0};
      test_reset();
      test_ex_forward();
      test_load_use();
      test_priority();
      test_flush();
      test_back_to_back();
`ifdef DCD_FWD_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
